// File: rtl/cmp_pkg.sv
// Shared compare-stage definitions: outcome encoding and default widths.
package cmp_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 8;

    typedef logic [1:0] cmp_outcome_t;

    localparam cmp_outcome_t CMP_LT = 2'd0;
    localparam cmp_outcome_t CMP_EQ = 2'd1;
    localparam cmp_outcome_t CMP_GT = 2'd2;

endpackage

// File: rtl/cmp_stream_stage_if.sv
// Operand/result handshake bundle plus counter debug signals for cmp_stream_stage.
interface cmp_stream_stage_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_gt;
    logic             out_lt;
    logic             out_eq;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_gt;
    logic [CNT_W-1:0] cnt_lt;
    logic [CNT_W-1:0] cnt_eq;

    // Source/consumer side
    modport master (
        output in_valid, in_a, in_b, out_ready, clr_cnt,
        input  in_ready, out_valid, out_a, out_b, out_gt, out_lt, out_eq,
        input  cnt_gt, cnt_lt, cnt_eq
    );

    // Stage side
    modport slave (
        input  in_valid, in_a, in_b, out_ready, clr_cnt,
        output in_ready, out_valid, out_a, out_b, out_gt, out_lt, out_eq,
        output cnt_gt, cnt_lt, cnt_eq
    );
endinterface

// File: rtl/cmp_mag.sv
// Combinational unsigned magnitude compare producing a single outcome code.
module cmp_mag
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output cmp_outcome_t     outcome_o
);

    always_comb begin
        outcome_o = CMP_EQ;
        if (a_i > b_i) begin
            outcome_o = CMP_GT;
        end else if (a_i < b_i) begin
            outcome_o = CMP_LT;
        end
    end

endmodule

// File: rtl/cmp_stream_stage.sv
// Single-entry registered compare stage with valid/ready handshake and
// saturating per-outcome accept counters.
module cmp_stream_stage
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp_stream_stage_if.slave    bus
);

    localparam int unsigned   N_OUT   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic [CNT_W-1:0] cnt_q    [N_OUT];
    logic [CNT_W-1:0] cnt_d    [N_OUT];
    logic [CNT_W-1:0] cnt_base [N_OUT];

    cmp_outcome_t outcome;
    logic         in_ready_c;
    logic         accept_c;

    cmp_mag #(.WIDTH(WIDTH)) u_mag (
        .a_i       (bus.in_a),
        .b_i       (bus.in_b),
        .outcome_o (outcome)
    );

    assign in_ready_c = !valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;

    // Next-state: load on accept, drop valid on a drain with nothing new behind it
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        if (accept_c) begin
            valid_d = 1'b1;
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            gt_d    = (outcome == CMP_GT);
            lt_d    = (outcome == CMP_LT);
            eq_d    = (outcome == CMP_EQ);
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Clear takes effect first so a same-cycle accept lands on a zeroed counter
    always_comb begin
        for (int k = 0; k < int'(N_OUT); k++) begin
            cnt_base[k] = bus.clr_cnt ? '0 : cnt_q[k];
            cnt_d[k]    = cnt_base[k];
            if (accept_c && (outcome == 2'(k)) && (cnt_base[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_base[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            for (int k = 0; k < int'(N_OUT); k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            for (int k = 0; k < int'(N_OUT); k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_gt    = gt_q;
    assign bus.out_lt    = lt_q;
    assign bus.out_eq    = eq_q;
    assign bus.cnt_lt    = cnt_q[CMP_LT];
    assign bus.cnt_eq    = cnt_q[CMP_EQ];
    assign bus.cnt_gt    = cnt_q[CMP_GT];

endmodule
